// File: rtl/aes128_cipher_top.sv
// ---------------------------------------------------------------------------
// aes128_cipher_top
//
// Iterative AES-128 encryption engine that computes one round per clock.
// A single-cycle load strobe captures the key and the plaintext. Eleven
// clocks after the load edge, text_out holds the ciphertext and done pulses
// for that one cycle. After done the key schedule and the state keep
// running, so text_out holds the ciphertext only on the done cycle.
//
// Ports
//   clk      : sole clock, rising edge
//   rst      : synchronous active-low reset, clears the round counter only
//   ld       : load strobe, starts or restarts an encryption
//   key      : 128-bit cipher key, sampled when ld = 1
//   text_in  : 128-bit plaintext, sampled when ld = 1
//   done     : registered one-cycle pulse marking text_out valid
//   text_out : registered final-round output, updated every clock
//
// Byte order is column-major: state byte s[r][c] sits at bits
// [127-8*(4c+r) -: 8]. Round-key word w0 is bits [127:96].
// ---------------------------------------------------------------------------

// Forward AES S-box as a constant lookup table. Entry n sits at bits
// [2047-8n -: 8], so the top bit of entry a is {~a, 3'b111}.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX_TABLE[{~a, 3'b111} -: 8];

endmodule

module aes128_cipher_top (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [127:0] key,
  input  logic [127:0] text_in,
  output logic         done,
  output logic [127:0] text_out
);

  // Multiply by x in GF(2^8) with the AES reduction polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row r is rotated left by r positions.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    shift_rows = o;
  endfunction

  // Each column is multiplied by the fixed polynomial {03}x^3+{01}x^2+{01}x+{02}.
  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    mix_columns = o;
  endfunction

  // Round constant for a given round-counter value. Values past the tenth
  // round yield zero, so the schedule keeps running without a constant.
  function automatic logic [7:0] rc_byte(input logic [3:0] n);
    case (n)
      4'd0:    rc_byte = 8'h01;
      4'd1:    rc_byte = 8'h02;
      4'd2:    rc_byte = 8'h04;
      4'd3:    rc_byte = 8'h08;
      4'd4:    rc_byte = 8'h10;
      4'd5:    rc_byte = 8'h20;
      4'd6:    rc_byte = 8'h40;
      4'd7:    rc_byte = 8'h80;
      4'd8:    rc_byte = 8'h1b;
      4'd9:    rc_byte = 8'h36;
      default: rc_byte = 8'h00;
    endcase
  endfunction

  logic [3:0]   dcnt_q, dcnt_d;
  logic [127:0] text_in_r_q, text_in_r_d;
  logic         ld_r_q, ld_r_d;
  logic [127:0] sa_q, sa_d;
  logic [127:0] w_q, w_d;
  logic [3:0]   rcnt_q, rcnt_d;
  logic [31:0]  rcon_q, rcon_d;
  logic         done_q, done_d;
  logic [127:0] text_out_q, text_out_d;

  logic [127:0] sub_bytes;
  logic [127:0] shifted;
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [31:0]  w0_n, w1_n, w2_n, w3_n;

  // Sixteen S-boxes substitute every state byte.
  for (genvar i = 0; i < 16; i++) begin : g_state_sbox
    aes_sbox u_sbox (
      .a (sa_q[127-8*i -: 8]),
      .y (sub_bytes[127-8*i -: 8])
    );
  end

  // RotWord moves the top byte of w3 to the bottom. Four S-boxes then
  // substitute the rotated word.
  assign rot_word = {w_q[23:0], w_q[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_key_sbox
    aes_sbox u_sbox (
      .a (rot_word[31-8*i -: 8]),
      .y (sub_word[31-8*i -: 8])
    );
  end

  assign shifted = shift_rows(sub_bytes);

  // Round datapath and key schedule. The cycle after a load, the state
  // takes the initial AddRoundKey. On every other cycle it takes a full
  // round. text_out always holds the final-round form, which has no
  // MixColumns.
  always_comb begin
    dcnt_d      = dcnt_q;
    text_in_r_d = text_in_r_q;
    ld_r_d      = ld;
    sa_d        = sa_q;
    w_d         = w_q;
    rcnt_d      = rcnt_q;
    rcon_d      = rcon_q;
    done_d      = 1'b0;
    text_out_d  = shifted ^ w_q;
    w0_n        = '0;
    w1_n        = '0;
    w2_n        = '0;
    w3_n        = '0;

    if (ld) begin
      dcnt_d = 4'd11;
    end else if (dcnt_q != 4'd0) begin
      dcnt_d = dcnt_q - 4'd1;
    end

    done_d = (dcnt_q == 4'd1) && !ld;

    if (ld) begin
      text_in_r_d = text_in;
    end

    if (ld_r_q) begin
      sa_d = text_in_r_q ^ w_q;
    end else begin
      sa_d = mix_columns(shifted) ^ w_q;
    end

    w0_n = w_q[127:96] ^ sub_word ^ rcon_q;
    w1_n = w0_n ^ w_q[95:64];
    w2_n = w1_n ^ w_q[63:32];
    w3_n = w2_n ^ w_q[31:0];

    if (ld) begin
      w_d    = key;
      rcnt_d = 4'd0;
      rcon_d = 32'h0100_0000;
    end else begin
      w_d    = {w0_n, w1_n, w2_n, w3_n};
      rcnt_d = rcnt_q + 4'd1;
      rcon_d = {rc_byte(rcnt_q + 4'd1), 24'h00_0000};
    end
  end

  // Only the round counter is reset. A cleared counter can never reach 1,
  // so a reset mid-run suppresses that run's done pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dcnt_q <= 4'd0;
    end else begin
      dcnt_q <= dcnt_d;
    end
  end

  // Data registers have no reset. A load makes their contents meaningful.
  always_ff @(posedge clk) begin
    text_in_r_q <= text_in_r_d;
    ld_r_q      <= ld_r_d;
    sa_q        <= sa_d;
    w_q         <= w_d;
    rcnt_q      <= rcnt_d;
    rcon_q      <= rcon_d;
    done_q      <= done_d;
    text_out_q  <= text_out_d;
  end

  assign done     = done_q;
  assign text_out = text_out_q;

endmodule

// File: tb/tb_aes128_cipher_top.sv
// ---------------------------------------------------------------------------
// tb_aes128_cipher_top
//
// Self-checking bench for aes128_cipher_top. The reference model derives the
// S-box from the GF(2^8) inverse and the affine map. It runs AES-128 as
// byte-level round functions, and it steps a cycle model of the round and
// key-schedule behaviour for the long idle run.
// ---------------------------------------------------------------------------
module tb_aes128_cipher_top;

  logic         clk;
  logic         rst;
  logic         ld;
  logic [127:0] key;
  logic [127:0] text_in;
  logic         done;
  logic [127:0] text_out;

  int checks;
  int errors;

  logic [7:0] sbox_m [256];

  aes128_cipher_top dut (
    .clk      (clk),
    .rst      (rst),
    .ld       (ld),
    .key      (key),
    .text_in  (text_in),
    .done     (done),
    .text_out (text_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [7:0] r;
    r = x;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (a != 0 && gf_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      end
      sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                  ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [7:0] get_b(input logic [127:0] s, input int r, input int c);
    return s[127-8*(4*c+r) -: 8];
  endfunction

  function automatic logic [127:0] m_sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(4*c+r) -: 8] = sbox_m[get_b(s, r, (c + r) % 4)];
    return o;
  endfunction

  function automatic logic [127:0] m_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    int           coef [4];
    logic [7:0]   acc;
    o = '0;
    coef[0] = 2; coef[1] = 3; coef[2] = 1; coef[3] = 1;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = get_b(s, r, c);
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gf_mul(8'(coef[(k - r + 4) % 4]), a[k]);
        o[127-8*(4*c+r) -: 8] = acc;
      end
    end
    return o;
  endfunction

  function automatic logic [7:0] rc_of(input int i);
    logic [7:0] rc;
    rc = 8'h01;
    if (i >= 10) return 8'h00;
    for (int k = 0; k < i; k++) rc = gf_mul(rc, 8'h02);
    return rc;
  endfunction

  function automatic logic [127:0] m_next_key(input logic [127:0] w, input logic [7:0] rc);
    logic [31:0] ww [4];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) ww[i] = w[127-32*i -: 32];
    t = {sbox_m[ww[3][23:16]], sbox_m[ww[3][15:8]], sbox_m[ww[3][7:0]],
         sbox_m[ww[3][31:24]]} ^ {rc, 24'h0};
    ww[0] = ww[0] ^ t;
    for (int i = 1; i < 4; i++) ww[i] = ww[i] ^ ww[i-1];
    return {ww[0], ww[1], ww[2], ww[3]};
  endfunction

  function automatic logic [127:0] m_encrypt(input logic [127:0] k, input logic [127:0] p);
    logic [127:0] s, w;
    s = p ^ k;
    w = k;
    for (int rnd = 1; rnd <= 10; rnd++) begin
      w = m_next_key(w, rc_of(rnd - 1));
      s = m_sub_shift(s);
      if (rnd < 10) s = m_mix(s);
      s = s ^ w;
    end
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- stimulus helpers ----------------

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [127:0] k, input logic [127:0] p);
    ld = 1'b1;
    key = k;
    text_in = p;
    tick();
    ld = 1'b0;
    key = rand128();
    text_in = rand128();
  endtask

  task automatic check_run(input string name, input logic [127:0] k,
                           input logic [127:0] p, input logic [127:0] exp_ct);
    do_load(k, p);
    for (int i = 1; i <= 11; i++) begin
      tick();
      checks++;
      if (done !== (i == 11)) begin
        errors++;
        $display("[TB] FAIL %s done at E%0d: got %b expected %b", name, i, done, (i == 11));
      end
    end
    checks++;
    if (text_out !== exp_ct) begin
      errors++;
      $display("[TB] FAIL %s ciphertext: got %h expected %h", name, text_out, exp_ct);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s done at E12: got %b expected 0", name, done);
    end
  endtask

  // ---------------- tests ----------------

  task automatic test_reset();
    rst = 1'b0;
    ld = 1'b0;
    key = '0;
    text_in = '0;
    tick();
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_done: got %b expected 0", done);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release_done: got %b expected 0", done);
    end
  endtask

  task automatic test_kat();
    check_run("fips_c1", 128'h000102030405060708090a0b0c0d0e0f,
              128'h00112233445566778899aabbccddeeff,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    check_run("fips_b", 128'h2b7e151628aed2a6abf7158809cf4f3c,
              128'h3243f6a8885a308d313198a2e0370734,
              128'h3925841d02dc09fbdc118597196a0b32);
  endtask

  task automatic test_random();
    logic [127:0] k, p;
    for (int n = 0; n < 6; n++) begin
      k = rand128();
      p = rand128();
      check_run("random", k, p, m_encrypt(k, p));
    end
  endtask

  task automatic test_restart();
    logic [127:0] k2, p2;
    k2 = rand128();
    p2 = rand128();
    do_load(rand128(), rand128());
    for (int i = 1; i <= 4; i++) tick();
    do_load(k2, p2);
    for (int i = 6; i <= 16; i++) begin
      tick();
      checks++;
      if (done !== (i == 16)) begin
        errors++;
        $display("[TB] FAIL restart done at E%0d: got %b expected %b", i, done, (i == 16));
      end
    end
    checks++;
    if (text_out !== m_encrypt(k2, p2)) begin
      errors++;
      $display("[TB] FAIL restart ciphertext: got %h expected %h", text_out, m_encrypt(k2, p2));
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] k2, p2;
    k2 = rand128();
    p2 = rand128();
    do_load(rand128(), rand128());
    for (int i = 1; i <= 10; i++) tick();
    do_load(k2, p2);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b done at E11: got %b expected 0", done);
    end
    for (int i = 12; i <= 22; i++) begin
      tick();
      checks++;
      if (done !== (i == 22)) begin
        errors++;
        $display("[TB] FAIL b2b done at E%0d: got %b expected %b", i, done, (i == 22));
      end
    end
    checks++;
    if (text_out !== m_encrypt(k2, p2)) begin
      errors++;
      $display("[TB] FAIL b2b ciphertext: got %h expected %h", text_out, m_encrypt(k2, p2));
    end
  endtask

  task automatic test_reset_midrun();
    logic [127:0] k, p;
    do_load(rand128(), rand128());
    for (int i = 1; i <= 3; i++) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 5; i <= 20; i++) begin
      tick();
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midrun_reset done at E%0d: got %b expected 0", i, done);
      end
    end
    k = rand128();
    p = rand128();
    check_run("after_reset", k, p, m_encrypt(k, p));
  endtask

  // Cycle model from E1 onward: the state holds P^K and the key holds
  // round key 1 with the round counter at 1. Each later edge applies one
  // full round to the state, exposes the final-round form on text_out and
  // advances the key with the constant for the current counter value.
  task automatic test_idle();
    logic [127:0] k, p, m_sa, m_w, exp_to;
    int           m_rcnt;
    k = rand128();
    p = rand128();
    do_load(k, p);
    tick();
    m_sa = p ^ k;
    m_w = m_next_key(k, rc_of(0));
    m_rcnt = 1;
    for (int e = 2; e <= 51; e++) begin
      exp_to = m_sub_shift(m_sa) ^ m_w;
      m_sa = m_mix(m_sub_shift(m_sa)) ^ m_w;
      m_w = m_next_key(m_w, rc_of(m_rcnt));
      m_rcnt = (m_rcnt + 1) % 16;
      tick();
      checks++;
      if (text_out !== exp_to) begin
        errors++;
        $display("[TB] FAIL idle text_out at E%0d: got %h expected %h", e, text_out, exp_to);
      end
      checks++;
      if (done !== (e == 11)) begin
        errors++;
        $display("[TB] FAIL idle done at E%0d: got %b expected %b", e, done, (e == 11));
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    ld = 1'b0;
    key = '0;
    text_in = '0;
    build_sbox();
    test_reset();
    test_kat();
    test_random();
    test_restart();
    test_back_to_back();
    test_reset_midrun();
    test_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
